thread_issue_sched: RTL

- Round-robin issue scheduler that selects one hardware thread per issue slot for the shared instruction-issue datapath.
- Holds a per-thread enable mask. The mask resets to all ones, so every thread is enabled out of reset.
- Arbitrates among threads that are both enabled and ready, and presents one registered grant with a valid/ack handshake.
- Sits between the per-thread instruction buffers and the shared operand fetch stage.

---
 rtl/thread_issue_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/thread_issue_sched.sv
// Round-robin issue scheduler: picks one enabled, ready hardware thread per issue slot
// and holds a registered grant until the operand-fetch stage acks it or the thread is killed.
module thread_issue_sched #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] thread_ready,
    input  logic [NUM_THREADS-1:0] thread_en_set,
    input  logic [NUM_THREADS-1:0] thread_en_clr,
    input  logic                   issue_ack,
    output logic                   issue_valid,
    output logic [NUM_THREADS-1:0] issue_oh,
    output logic [TID_W-1:0]       issue_tid,
    output logic [NUM_THREADS-1:0] thread_en
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_nstate;
    logic [NUM_THREADS-1:0] r_en;
    logic [NUM_THREADS-1:0] r_oh;
    logic [NUM_THREADS-1:0] w_noh;
    logic [TID_W-1:0]       r_tid;
    logic [TID_W-1:0]       w_ntid;
    logic [TID_W-1:0]       r_last;
    logic [TID_W-1:0]       w_nlast;
    logic [TID_W-1:0]       w_ptr;
    logic [TID_W-1:0]       w_sel_tid;
    logic [NUM_THREADS-1:0] w_sel_oh;
    logic [NUM_THREADS-1:0] w_cand;
    logic                   w_any;

    // First set bit of c searching upward from last+1, wrapping around.
    function automatic logic [TID_W-1:0] rr_pick(input logic [NUM_THREADS-1:0] c,
                                                 input logic [TID_W-1:0]       last);
        logic             found;
        logic [TID_W-1:0] result;
        int               idx;
        found  = 1'b0;
        result = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            idx = (int'(last) + i) % NUM_THREADS;
            if (!found && c[idx]) begin
                result = TID_W'(idx);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // A same-cycle clear masks its thread at once; a set only lands via r_en next cycle.
    assign w_cand = r_en & thread_ready & ~thread_en_clr;
    assign w_any  = |w_cand;
    // On an ack the thread just issued becomes lowest priority for the reselection.
    assign w_ptr  = (r_state == GRANT && issue_ack) ? r_tid : r_last;

    always_comb begin
        w_sel_tid           = rr_pick(w_cand, w_ptr);
        w_sel_oh            = '0;
        w_sel_oh[w_sel_tid] = 1'b1;
    end

    always_comb begin
        w_nstate = r_state;
        w_noh    = r_oh;
        w_ntid   = r_tid;
        w_nlast  = r_last;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nstate = GRANT;
                    w_noh    = w_sel_oh;
                    w_ntid   = w_sel_tid;
                end
            end
            GRANT: begin
                if (issue_ack) begin
                    w_nlast = r_tid;
                    if (w_any) begin
                        w_noh  = w_sel_oh;
                        w_ntid = w_sel_tid;
                    end else begin
                        w_nstate = IDLE;
                        w_noh    = '0;
                        w_ntid   = '0;
                    end
                end else if (thread_en_clr[r_tid]) begin
                    w_nstate = IDLE;
                    w_noh    = '0;
                    w_ntid   = '0;
                end
            end
            default: begin
                w_nstate = IDLE;
                w_noh    = '0;
                w_ntid   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_en    <= '1;
            r_oh    <= '0;
            r_tid   <= '0;
            r_last  <= TID_W'(NUM_THREADS - 1);
        end else begin
            r_state <= w_nstate;
            r_en    <= (r_en | thread_en_set) & ~thread_en_clr;
            r_oh    <= w_noh;
            r_tid   <= w_ntid;
            r_last  <= w_nlast;
        end
    end

    assign issue_valid = (r_state == GRANT);
    assign issue_oh    = r_oh;
    assign issue_tid   = r_tid;
    assign thread_en   = r_en;

endmodule
